// File: rtl/wallace_pkg.sv
// Shared definitions for the pipelined Wallace-tree multiplier: default width,
// pipeline depth, Baugh-Wooley correction and reduction-tree shape helpers.
package wallace_pkg;

  localparam int W_DEFAULT   = 8;
  localparam int PIPE_STAGES = 3;

  // Signed-mode correction row: ones at bit w and bit 2w-1.
  function automatic logic [63:0] bw_corr(input int w);
    logic [63:0] c;
    c          = '0;
    c[w]       = 1'b1;
    c[2*w-1]   = 1'b1;
    return c;
  endfunction

  // Rows present at a given tree level; level 0 holds w partial products
  // plus the correction row.
  function automatic int tree_rows(input int w, input int level);
    int n;
    n = w + 1;
    for (int l = 0; l < level; l++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  // Number of 3:2 levels needed to reach two rows.
  function automatic int tree_levels(input int w);
    int n;
    int l;
    n = w + 1;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the reduction tree.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/wallace_mult_pipe_csa_row.sv
// N-bit 3:2 compressor row; the carry row is returned already shifted left
// by one and truncated to N bits.
module csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] carry_o
);

  logic [N-2:0] cy;

  for (genvar k = 0; k < N - 1; k++) begin : g_fa
    full_adder u_fa (
      .a_i  (a_i[k]),
      .b_i  (b_i[k]),
      .ci_i (c_i[k]),
      .s_o  (sum_o[k]),
      .co_o (cy[k])
    );
  end

  // The top carry would land at bit N, outside the product, so only the sum
  // is needed there.
  assign sum_o[N-1] = a_i[N-1] ^ b_i[N-1] ^ c_i[N-1];
  assign carry_o    = {cy, 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage W x W Wallace-tree multiplier with per-transaction signed mode
// and a single global stall driven by the output handshake.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_prod
);

  localparam int              PW        = 2 * W;
  localparam int              NROWS     = W + 1;
  localparam int              LEVELS    = tree_levels(W);
  localparam logic [63:0]     CORR_FULL = bw_corr(W);
  localparam logic [PW-1:0]   CORR      = CORR_FULL[PW-1:0];

  logic          adv;
  logic          v1_q, v2_q, v3_q;
  logic [W-1:0]  a_q, b_q;
  logic          sgn_q;
  logic [PW-1:0] pp_rows [NROWS];
  logic [PW-1:0] sum_d, carry_d, sum_q, carry_q;
  logic [PW-1:0] prod_d, prod_q;

  assign adv       = ~v3_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = v3_q;
  assign out_prod  = prod_q;

  // Baugh-Wooley: in signed mode the cross terms with exactly one MSB operand
  // bit are inverted and the correction row is added.
  // NOTE: every row gets a full default before bit writes, so no latch forms.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      pp_rows[i] = '0;
      for (int j = 0; j < W; j++) begin
        pp_rows[i][i+j] = (a_q[j] & b_q[i]) ^ (sgn_q & ((i == W - 1) != (j == W - 1)));
      end
    end
    pp_rows[W] = sgn_q ? CORR : '0;
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = tree_rows(W, l);
    logic [PW-1:0] rows [N];

    if (l == 0) begin : g_src
      for (genvar r = 0; r < N; r++) begin : g_row
        assign rows[r] = pp_rows[r];
      end
    end else begin : g_red
      localparam int NP = tree_rows(W, l - 1);
      localparam int NG = NP / 3;

      for (genvar g = 0; g < NG; g++) begin : g_csa
        csa_row #(.N(PW)) u_csa (
          .a_i     (g_lvl[l-1].rows[3*g]),
          .b_i     (g_lvl[l-1].rows[3*g+1]),
          .c_i     (g_lvl[l-1].rows[3*g+2]),
          .sum_o   (rows[2*g]),
          .carry_o (rows[2*g+1])
        );
      end

      for (genvar p = 0; p < NP % 3; p++) begin : g_pass
        assign rows[2*NG+p] = g_lvl[l-1].rows[3*NG+p];
      end
    end
  end

  assign sum_d   = g_lvl[LEVELS].rows[0];
  assign carry_d = g_lvl[LEVELS].rows[1];
  assign prod_d  = sum_q + carry_q;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      prod_q <= '0;
    end else if (adv) begin
      v1_q   <= in_valid;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      prod_q <= prod_d;
    end
  end

  // NOTE: operand and row registers carry no reset; the valid bits alone
  // decide whether their contents ever reach the output.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_q     <= in_a;
      b_q     <= in_b;
      sgn_q   <= in_signed;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench: W=4, 8 and 16 instances share one stimulus stream and
// are scored against an arithmetic reference model with a transaction queue.
module tb_wallace_mult_pipe;
  import wallace_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    int          cyc;
    int          stalls;
  } txn_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_signed;
  logic        out_ready;
  logic [15:0] a_r, b_r;

  logic        in_ready4, out_valid4;
  logic [7:0]  out_prod4;
  logic        in_ready8, out_valid8;
  logic [15:0] out_prod8;
  logic        in_ready16, out_valid16;
  logic [31:0] out_prod16;

  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   stalls;
  bit   exp_ov;
  bit   done;
  txn_t q[$];
  txn_t e;

  wallace_mult_pipe #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(a_r[3:0]), .in_b(b_r[3:0]), .in_signed(in_signed),
    .out_valid(out_valid4), .out_ready(out_ready), .out_prod(out_prod4)
  );

  wallace_mult_pipe #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(a_r[7:0]), .in_b(b_r[7:0]), .in_signed(in_signed),
    .out_valid(out_valid8), .out_ready(out_ready), .out_prod(out_prod8)
  );

  wallace_mult_pipe #(.W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(a_r), .in_b(b_r), .in_signed(in_signed),
    .out_valid(out_valid16), .out_ready(out_ready), .out_prod(out_prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Exact product of the low w bits of a and b, reduced mod 2^(2w).
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic sgn, input int w);
    longint m, av, bv, p;
    m  = (longint'(1) << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (sgn && av >= (longint'(1) << (w - 1))) av -= longint'(1) << w;
    if (sgn && bv >= (longint'(1) << (w - 1))) bv -= longint'(1) << w;
    p = av * bv;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Reference: a transaction becomes visible once it has aged PIPE_STAGES
  // non-stalled cycles, and leaves when the consumer takes it.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      exp_ov = 1'b0;
      if (q.size() > 0)
        exp_ov = (cyc - q[0].cyc - (stalls - q[0].stalls)) >= PIPE_STAGES;
      check("out_valid4",  out_valid4,  exp_ov);
      check("out_valid8",  out_valid8,  exp_ov);
      check("out_valid16", out_valid16, exp_ov);
      check("in_ready4",   in_ready4,   !exp_ov || out_ready);
      check("in_ready8",   in_ready8,   !exp_ov || out_ready);
      check("in_ready16",  in_ready16,  !exp_ov || out_ready);
      if (exp_ov) begin
        e = q[0];
        check("prod4",  out_prod4,  ref_mul(e.a, e.b, e.sgn, 4));
        check("prod8",  out_prod8,  ref_mul(e.a, e.b, e.sgn, 8));
        check("prod16", out_prod16, ref_mul(e.a, e.b, e.sgn, 16));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && (!exp_ov || out_ready))
        q.push_back('{a: a_r, b: b_r, sgn: in_signed, cyc: cyc, stalls: stalls});
      if (exp_ov && !out_ready) stalls++;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    int k;
    in_valid  = 1'b1;
    a_r       = a;
    b_r       = b;
    in_signed = sgn;
    k = 0;
    @(negedge clk);
    while (!in_ready8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready8) check("in_ready_timeout", in_ready8, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_prod4",  out_prod4,  '0);
    check("rst_prod8",  out_prod8,  '0);
    check("rst_prod16", out_prod16, '0);
    check("rst_ready8", in_ready8,  1'b1);
    step();
  endtask

  initial begin
    #900_000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [8:0] iv;
    n_cmp     = 0;
    n_bad     = 0;
    cyc       = 0;
    stalls    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    a_r       = '0;
    b_r       = '0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_state();

    // Unsigned back-to-back, then signed corners followed by an unsigned 0x80*0x80.
    send(16'd255, 16'd255, 1'b0);
    send(16'd0,   16'd200, 1'b0);
    send(16'd15,  16'd17,  1'b0);
    idle(6);
    send(16'h0080, 16'h0080, 1'b1);
    send(16'h00FF, 16'h0001, 1'b1);
    send(16'h007F, 16'h0080, 1'b1);
    send(16'h0080, 16'h0080, 1'b0);
    idle(6);

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 10; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
      end
      begin
        repeat (4) step();
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
      end
    join
    idle(6);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state();
    send(16'd100, 16'd3, 1'b0);
    idle(6);

    // Bubbles.
    send(16'd7, 16'd9, 1'b0);
    idle(1);
    send(16'hFFF9, 16'h0005, 1'b1);
    idle(7);

    // Exhaustive over the low nibbles (W=4 sees every pair in both modes).
    for (int i = 0; i < 512; i++) begin
      iv = 9'(i);
      send((16'($urandom) & 16'hFFF0) | 16'(iv[3:0]),
           (16'($urandom) & 16'hFFF0) | 16'(iv[7:4]), iv[8]);
    end
    idle(6);

    // Random stream with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(8);

    check("drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
